player_motion: RTL

//  Knight motion controller, directly upstream of the player sprite mapper.

---
 rtl/hk_pkg.sv | 22 ++
 rtl/frame_tick_sync.sv | 38 +++
 rtl/player_motion.sv | 139 +++++++++++++
 3 files changed

// File: rtl/hk_pkg.sv
// Shared types and keycodes for the frame-rate game blocks.
// Status encoding is what the sprite mapper consumes directly.
package hk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    JUMP = 2'd2,
    FALL = 2'd3
  } player_status_t;

  localparam logic [7:0] KEY_LEFT    = 8'h04;
  localparam logic [7:0] KEY_RIGHT   = 8'h07;
  localparam logic [7:0] KEY_JUMP_W  = 8'h1A;
  localparam logic [7:0] KEY_JUMP_SP = 8'h2C;

  function automatic logic key_hit(input logic [7:0] k0, input logic [7:0] k1,
                                   input logic [7:0] code);
    return (k0 == code) || (k1 == code);
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings an asynchronous frame-rate strobe into Clk and emits a one-cycle tick
// on its rising edge; tick appears 3 Clk after the input rises.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic async_in,
  output logic tick
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic tick_q, tick_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    tick_d  = sync2_q & ~prev_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/player_motion.sv
// Knight motion controller: once per frame tick integrates walk, jump and gravity.
// Outputs are registered and move 1 Clk after frame_tick.
module player_motion
  import hk_pkg::*;
#(
  parameter int X_RESET    = 320,
  parameter int GROUND_Y   = 400,
  parameter int X_MIN      = 24,
  parameter int X_MAX      = 615,
  parameter int WALK_SPEED = 2,
  parameter int JUMP_V     = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL   = 8,
  parameter int SIZE_X     = 40,
  parameter int SIZE_Y     = 60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  output logic [9:0] Player_X,
  output logic [9:0] Player_Y,
  output logic [9:0] Player_SizeX,
  output logic [9:0] Player_SizeY,
  output logic [3:0] Player_Status,
  output logic       Inverse,
  output logic       frame_tick
);

  localparam logic signed [10:0] X_MIN_S    = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_S    = 11'(X_MAX);
  localparam logic signed [10:0] WALK_S     = 11'(WALK_SPEED);
  localparam logic signed [10:0] GROUND_S   = 11'(GROUND_Y);
  localparam logic signed [7:0]  JUMP_V_S   = 8'(JUMP_V);
  localparam logic signed [7:0]  GRAV_S     = 8'(GRAVITY);
  localparam logic signed [7:0]  MAX_FALL_S = 8'(MAX_FALL);

  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic signed [7:0] vy_q, vy_d;
  player_status_t    status_q, status_d;
  logic              inverse_q, inverse_d;
  logic              jump_prev_q, jump_prev_d;

  logic                 tick;
  logic                 left, right, jump, jump_edge, airborne;
  player_status_t       ground_status;
  logic signed [10:0]   x_s, y_step;
  logic signed [7:0]    vy_n;

  frame_tick_sync u_sync (
    .Clk      (Clk),
    .Reset    (Reset),
    .async_in (frame_clk),
    .tick     (tick)
  );

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    vy_d        = vy_q;
    status_d    = status_q;
    inverse_d   = inverse_q;
    jump_prev_d = jump_prev_q;

    left          = key_hit(keycode0, keycode1, KEY_LEFT);
    right         = key_hit(keycode0, keycode1, KEY_RIGHT);
    jump          = key_hit(keycode0, keycode1, KEY_JUMP_W) |
                    key_hit(keycode0, keycode1, KEY_JUMP_SP);
    jump_edge     = jump & ~jump_prev_q;
    airborne      = (status_q == JUMP) || (status_q == FALL);
    ground_status = (left ^ right) ? WALK : IDLE;

    // Signed 11-bit so a step below X_MIN cannot wrap to a large value
    x_s = $signed({1'b0, x_q});
    if (left && !right) begin
      x_s = x_s - WALK_S;
      if (x_s < X_MIN_S) x_s = X_MIN_S;
    end else if (right && !left) begin
      x_s = x_s + WALK_S;
      if (x_s > X_MAX_S) x_s = X_MAX_S;
    end

    if (airborne) begin
      vy_n = vy_q + GRAV_S;
      if (vy_n > MAX_FALL_S) vy_n = MAX_FALL_S;
    end else begin
      vy_n = -JUMP_V_S;
    end
    y_step = $signed({1'b0, y_q}) + $signed({{3{vy_n[7]}}, vy_n});

    if (tick) begin
      x_d         = x_s[9:0];
      jump_prev_d = jump;
      if (left && !right)      inverse_d = 1'b1;
      else if (right && !left) inverse_d = 1'b0;

      if (airborne && (y_step >= GROUND_S)) begin
        y_d      = GROUND_Y[9:0];
        vy_d     = 8'sd0;
        status_d = ground_status;
      end else if (airborne || jump_edge) begin
        y_d      = (y_step < 11'sd0) ? 10'd0 : y_step[9:0];
        vy_d     = vy_n;
        status_d = vy_n[7] ? JUMP : FALL;
      end else begin
        status_d = ground_status;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_q         <= X_RESET[9:0];
      y_q         <= GROUND_Y[9:0];
      vy_q        <= 8'sd0;
      status_q    <= IDLE;
      inverse_q   <= 1'b0;
      jump_prev_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      vy_q        <= vy_d;
      status_q    <= status_d;
      inverse_q   <= inverse_d;
      jump_prev_q <= jump_prev_d;
    end
  end

  assign Player_X      = x_q;
  assign Player_Y      = y_q;
  assign Player_SizeX  = SIZE_X[9:0];
  assign Player_SizeY  = SIZE_Y[9:0];
  assign Player_Status = {2'b00, status_q};
  assign Inverse       = inverse_q;
  assign frame_tick    = tick;

endmodule
